// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback queue.
package wb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] dest;
  } wb_entry_t;

  // Count needs one extra bit so a completely full queue is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer with two ordered write ports (port0 lands first) and one read port.
// Exposes per-entry valid/dest so the top level can run hazard compares.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push0_i,
  input  wb_entry_t                      entry0_i,
  input  logic                           push1_i,
  input  wb_entry_t                      entry1_i,
  input  logic                           pop_i,
  output wb_entry_t                      head_o,
  output logic [CNT_W-1:0]               count_o,
  output logic [DEPTH-1:0]               valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]   dest_o
);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wptr_p1;
  logic             pop_en;

  assign wptr_p1 = wptr_q + PTR_W'(1);
  assign pop_en  = pop_i && (count_q != '0);

  always_comb begin
    mem_d = mem_q;
    if (push0_i) begin
      mem_d[wptr_q] = entry0_i;
    end
    // A lone port1 push takes the slot port0 would have used.
    if (push1_i) begin
      mem_d[push0_i ? wptr_p1 : wptr_q] = entry1_i;
    end
    wptr_d  = wptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
    rptr_d  = rptr_q + PTR_W'(pop_en);
    count_d = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_en);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    valid_o = '0;
    dest_o  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      // Distance from the head decides whether slot i is occupied.
      valid_o[i] = CNT_W'(PTR_W'(i) - rptr_q) < count_q;
      dest_o[i]  = mem_q[i].dest;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/writeback_queue.sv
// Orders ALU and load results into the single register-file write port, one write per cycle,
// and flags read-after-write hazards for both read addresses.
module writeback_queue
  import wb_pkg::wb_entry_t, wb_pkg::cnt_width;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = wb_pkg::DATA_W,
  parameter int unsigned ADDR_W = wb_pkg::ADDR_W,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALU_VALID,
  input  logic [DATA_W-1:0] ALU_RESULT,
  input  logic [ADDR_W-1:0] ALU_DEST,
  input  logic              MEM_VALID,
  input  logic [DATA_W-1:0] MEM_DATA,
  input  logic [ADDR_W-1:0] MEM_DEST,
  input  logic [ADDR_W-1:0] RD1ADDRESS,
  input  logic [ADDR_W-1:0] RD2ADDRESS,
  output logic              WRITE,
  output logic [DATA_W-1:0] WDATA,
  output logic [ADDR_W-1:0] WADDRESS,
  output logic              HAZARD1,
  output logic              HAZARD2,
  output logic              FULL,
  output logic [CNT_W-1:0]  COUNT,
  output logic              OVERFLOW
);

  wb_entry_t                    mem_entry, alu_entry, head;
  logic                         push_mem, push_alu, pop;
  logic [CNT_W-1:0]             count;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_dest;

  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              ovf_q, ovf_d;

  assign mem_entry = '{data: MEM_DATA, dest: MEM_DEST};
  assign alu_entry = '{data: ALU_RESULT, dest: ALU_DEST};

  // Full leaves room for a dual push, so a non-full queue never overflows.
  assign FULL     = count >= CNT_W'(DEPTH - 1);
  assign push_mem = MEM_VALID && !FULL;
  assign push_alu = ALU_VALID && !FULL;
  assign pop      = count != '0;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .push0_i  (push_mem),
    .entry0_i (mem_entry),
    .push1_i  (push_alu),
    .entry1_i (alu_entry),
    .pop_i    (pop),
    .head_o   (head),
    .count_o  (count),
    .valid_o  (ent_valid),
    .dest_o   (ent_dest)
  );

  always_comb begin
    write_d = pop;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    if (pop) begin
      wdata_d = head.data;
      waddr_d = head.dest;
    end
    ovf_d = ovf_q || (FULL && (ALU_VALID || MEM_VALID));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      write_q <= 1'b0;
      wdata_q <= '0;
      waddr_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      write_q <= write_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      ovf_q   <= ovf_d;
    end
  end

  // The write being presented this cycle still counts as pending.
  always_comb begin
    HAZARD1 = write_q && (waddr_q == RD1ADDRESS);
    HAZARD2 = write_q && (waddr_q == RD2ADDRESS);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_dest[i] == RD1ADDRESS)) HAZARD1 = 1'b1;
      if (ent_valid[i] && (ent_dest[i] == RD2ADDRESS)) HAZARD2 = 1'b1;
    end
  end

  assign WRITE    = write_q;
  assign WDATA    = wdata_q;
  assign WADDRESS = waddr_q;
  assign COUNT    = count;
  assign OVERFLOW = ovf_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with hand-computed expectations.
module tb_writeback_queue;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ALU_VALID, MEM_VALID;
  logic [7:0] ALU_RESULT, MEM_DATA;
  logic [2:0] ALU_DEST, MEM_DEST, RD1ADDRESS, RD2ADDRESS;
  logic       WRITE, HAZARD1, HAZARD2, FULL, OVERFLOW;
  logic [7:0] WDATA;
  logic [2:0] WADDRESS, COUNT;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  writeback_queue #(
    .DEPTH (4)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ALU_VALID  (ALU_VALID),
    .ALU_RESULT (ALU_RESULT),
    .ALU_DEST   (ALU_DEST),
    .MEM_VALID  (MEM_VALID),
    .MEM_DATA   (MEM_DATA),
    .MEM_DEST   (MEM_DEST),
    .RD1ADDRESS (RD1ADDRESS),
    .RD2ADDRESS (RD2ADDRESS),
    .WRITE      (WRITE),
    .WDATA      (WDATA),
    .WADDRESS   (WADDRESS),
    .HAZARD1    (HAZARD1),
    .HAZARD2    (HAZARD2),
    .FULL       (FULL),
    .COUNT      (COUNT),
    .OVERFLOW   (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and settle just after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic w, input logic [7:0] d, input logic [2:0] a);
    check({tag, ".write"}, 32'(WRITE), 32'(w));
    check({tag, ".wdata"}, 32'(WDATA), 32'(d));
    check({tag, ".waddr"}, 32'(WADDRESS), 32'(a));
  endtask

  task automatic drive(input logic mv, input logic [7:0] md, input logic [2:0] ma,
                       input logic av, input logic [7:0] ad, input logic [2:0] aa);
    MEM_VALID = mv; MEM_DATA = md; MEM_DEST = ma;
    ALU_VALID = av; ALU_RESULT = ad; ALU_DEST = aa;
  endtask

  initial begin
    RESET = 1'b1;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0);
    RD1ADDRESS = 3'd7;
    RD2ADDRESS = 3'd7;
    #1;
    check("rst.count", 32'(COUNT), 32'd0);
    check("rst.ovf", 32'(OVERFLOW), 32'd0);
    check("rst.full", 32'(FULL), 32'd0);
    chk_wr("rst", 1'b0, 8'h00, 3'd0);
    step();
    step();
    RESET = 1'b0;

    // Single ALU result: latency of one edge into the queue, one edge out.
    drive(1'b0, 8'h00, 3'd0, 1'b1, 8'h5A, 3'd3);
    step();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0);
    check("t1.count_q", 32'(COUNT), 32'd1);
    check("t1.nowrite", 32'(WRITE), 32'd0);
    step();
    chk_wr("t1.out", 1'b1, 8'h5A, 3'd3);
    check("t1.count0", 32'(COUNT), 32'd0);
    step();
    chk_wr("t1.idle", 1'b0, 8'h5A, 3'd3);

    // Dual push in one cycle: MEM is older, written first.
    drive(1'b1, 8'h11, 3'd2, 1'b1, 8'h22, 3'd5);
    step();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0);
    check("t2.count", 32'(COUNT), 32'd2);
    step();
    chk_wr("t2.first", 1'b1, 8'h11, 3'd2);
    step();
    chk_wr("t2.second", 1'b1, 8'h22, 3'd5);
    step();
    check("t2.idle", 32'(WRITE), 32'd0);

    // Fill to FULL, push while full is dropped and flags overflow.
    drive(1'b1, 8'hA1, 3'd1, 1'b1, 8'hA2, 3'd2);
    step();
    check("t3.c2", 32'(COUNT), 32'd2);
    check("t3.nfull", 32'(FULL), 32'd0);
    drive(1'b1, 8'hB1, 3'd3, 1'b1, 8'hB2, 3'd4);
    step();
    check("t3.c3", 32'(COUNT), 32'd3);
    check("t3.full", 32'(FULL), 32'd1);
    check("t3.ovf0", 32'(OVERFLOW), 32'd0);
    chk_wr("t3.w1", 1'b1, 8'hA1, 3'd1);
    drive(1'b1, 8'hC1, 3'd5, 1'b1, 8'hC2, 3'd6);
    step();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0);
    check("t3.ovf1", 32'(OVERFLOW), 32'd1);
    check("t3.c2b", 32'(COUNT), 32'd2);
    check("t3.full0", 32'(FULL), 32'd0);
    chk_wr("t3.w2", 1'b1, 8'hA2, 3'd2);
    step();
    chk_wr("t3.w3", 1'b1, 8'hB1, 3'd3);
    step();
    chk_wr("t3.w4", 1'b1, 8'hB2, 3'd4);
    check("t3.c0", 32'(COUNT), 32'd0);
    step();
    chk_wr("t3.drop1", 1'b0, 8'hB2, 3'd4);
    check("t3.ovf_sticky", 32'(OVERFLOW), 32'd1);
    step();
    check("t3.drop2", 32'(WRITE), 32'd0);

    // Hazards: incoming result does not count, queued and in-write entries do.
    RD1ADDRESS = 3'd4;
    RD2ADDRESS = 3'd1;
    drive(1'b0, 8'h00, 3'd0, 1'b1, 8'h44, 3'd4);
    #1;
    check("t4.h1_incoming", 32'(HAZARD1), 32'd0);
    step();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0);
    #1;
    check("t4.h1_queued", 32'(HAZARD1), 32'd1);
    check("t4.h2_queued", 32'(HAZARD2), 32'd0);
    RD2ADDRESS = 3'd4;
    #1;
    check("t4.h2_match", 32'(HAZARD2), 32'd1);
    RD2ADDRESS = 3'd1;
    step();
    chk_wr("t4.w", 1'b1, 8'h44, 3'd4);
    check("t4.h1_write", 32'(HAZARD1), 32'd1);
    step();
    check("t4.h1_clear", 32'(HAZARD1), 32'd0);

    // Same destination twice: later result is written last.
    drive(1'b0, 8'h00, 3'd0, 1'b1, 8'hAA, 3'd6);
    step();
    drive(1'b0, 8'h00, 3'd0, 1'b1, 8'hBB, 3'd6);
    step();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0);
    chk_wr("t5.first", 1'b1, 8'hAA, 3'd6);
    step();
    chk_wr("t5.second", 1'b1, 8'hBB, 3'd6);
    step();
    chk_wr("t5.final", 1'b0, 8'hBB, 3'd6);

    // Asynchronous reset with three entries queued and a write in flight.
    drive(1'b1, 8'hD0, 3'd1, 1'b1, 8'hD1, 3'd2);
    step();
    drive(1'b1, 8'hD2, 3'd3, 1'b1, 8'hD3, 3'd4);
    step();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 3'd0);
    check("t6.pre_count", 32'(COUNT), 32'd3);
    chk_wr("t6.pre", 1'b1, 8'hD0, 3'd1);
    #2;
    RESET = 1'b1;
    #1;
    chk_wr("t6.async", 1'b0, 8'h00, 3'd0);
    check("t6.count", 32'(COUNT), 32'd0);
    check("t6.ovf", 32'(OVERFLOW), 32'd0);
    step();
    check("t6.held", 32'(WRITE), 32'd0);
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t6.post%0d", i), 32'(WRITE), 32'd0);
    end
    check("t6.post_count", 32'(COUNT), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
- Write-side sequencer for the 8-entry x 8-bit register file.
- Accepts results from two producers, ALU and data-memory load, each able to deliver one result per cycle.
- Queues them in program order and drains exactly one write per cycle into the register file's single write port.
- Reports read-after-write hazards to the control unit for the two register-file read addresses.

Parameters:
DEPTH, 4, queue entries (power of 2, >= 2)
DATA_W, 8, register data width
ADDR_W, 3, register address width

Ports:
CLK  in  1  system clock, all state updates on posedge
RESET  in  1  asynchronous, active-high reset
ALU_VALID  in  1  ALU result present this cycle
ALU_RESULT  in  DATA_W  ALU result data
ALU_DEST  in  ADDR_W  ALU destination register
MEM_VALID  in  1  load data present this cycle
MEM_DATA  in  DATA_W  load data
MEM_DEST  in  ADDR_W  load destination register
RD1ADDRESS  in  ADDR_W  register-file read port 1 address (hazard check)
RD2ADDRESS  in  ADDR_W  register-file read port 2 address (hazard check)
WRITE  out  1  register-file write enable
WDATA  out  DATA_W  register-file write data
WADDRESS  out  ADDR_W  register-file write address
HAZARD1  out  1  RD1ADDRESS has a pending write
HAZARD2  out  1  RD2ADDRESS has a pending write
FULL  out  1  producers must not assert VALID
COUNT  out  log2(DEPTH)+1  queued entries
OVERFLOW  out  1  sticky: a result was dropped

Behaviour:
- Clock and reset: one clock CLK. Reset RESET is asynchronous and active-high.
- Reset (asserted at any time, including mid-drain):
  - count=0, read/write pointers=0.
  - WRITE=0, WDATA=0, WADDRESS=0, OVERFLOW=0.
  - Queued entries are discarded and no write is issued.
  - Outputs stay at reset values while RESET is high.
- FULL = (COUNT >= DEPTH-1), derived from registered count. Guarantees room for two pushes.
- Push, at a posedge with FULL=0:
  - MEM entry is enqueued first (older instruction), ALU entry second.
  - 0, 1 or 2 pushes per cycle.
- Push while FULL=1: both inputs are ignored. OVERFLOW is set if either VALID is high and stays high until RESET.
- Pop, at each posedge with count>0 (count sampled before this edge's pushes):
  - Head entry is loaded into output registers: WRITE<=1, WDATA<=data, WADDRESS<=dest. Head is removed.
- Idle: if count=0 at the edge, WRITE<=0. WDATA/WADDRESS hold their last values.
- No bypass from input to output. Minimum latency: a result sampled at edge k drives WRITE=1 after edge k+1 and is held for one cycle.
- Count update: count_next = count + pushes - pop, in one edge. Pointers wrap modulo DEPTH.
- Same destination in the queue more than once: entries are written in queue order, so the latest result wins in the register file.
- HAZARD1 (combinational) = RD1ADDRESS equals the dest of any valid queue entry, OR (WRITE=1 and WADDRESS == RD1ADDRESS). HAZARD2 is the same for RD2ADDRESS.
- Incoming VALID inputs in the current cycle do not contribute to hazards; the control unit already tracks in-flight instructions.
- Outputs WRITE/WDATA/WADDRESS are registered with no combinational path from inputs. The register file applies its own write delay.

Decomposition:
- Shared package wb_pkg:
  - DATA_W and ADDR_W constants.
  - wb_entry_t typedef {data[DATA_W], dest[ADDR_W]}.
  - Function computing count width from DEPTH.
- Sub-module wb_fifo:
  - Circular buffer, 2 write ports, 1 read port, ordered push (port0 before port1).
  - Exports per-entry valid+dest vectors for the hazard comparators.
- Top level holds: the output register stage, FULL/OVERFLOW logic and the hazard compare.

Test Plan:
- RESET pulse, then ALU_VALID=1, ALU_RESULT=8'h5A, ALU_DEST=3 for one cycle -> WRITE=1, WDATA=8'h5A, WADDRESS=3 exactly one cycle after the following edge; COUNT returns to 0.
- Same cycle: MEM_VALID with 8'h11 to reg 2 and ALU_VALID with 8'h22 to reg 5 -> two consecutive WRITE cycles, first (2, 8'h11), then (5, 8'h22).
- Both producers push every cycle -> FULL asserts at COUNT=3. Further VALID while FULL sets OVERFLOW=1; the dropped data is never written; the queue drains in order.
- Queue holds dest 4, RD1ADDRESS=4, RD2ADDRESS=1 -> HAZARD1=1, HAZARD2=0. HAZARD1 stays high through the WRITE cycle for reg 4 and clears the cycle after.
- Two entries to reg 6 (8'hAA then 8'hBB) -> writes occur in that order; final WDATA for reg 6 is 8'hBB.
- Assert RESET asynchronously with 3 entries queued and WRITE=1 -> WRITE drops immediately, COUNT=0, OVERFLOW=0, no further writes after release.
